// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encoding, parity-type
//                selectors and line-level constants. Used by TX and RX.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame-level FSM states, shared between transmitter and receiver
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity type select values
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    // Line levels
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : parity_calc
//  Description : Combinational parity generator. XOR-reduces the data word
//                and inverts the result for odd parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    // Even parity is the plain XOR reduction; odd parity is its complement
    assign par_bit_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule : parity_calc
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter. One CLK cycle per bit. Frame is start bit,
//                DATA_WIDTH data bits LSB first, optional parity, one stop
//                bit. Back-to-back frames accepted during the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    // Counter width guarded so a 1-bit payload still gets a legal vector
    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    uart_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    accept_d;
    logic                    last_bit_d;
    logic                    par_bit_d;

    // A new frame can start only while the line is idle or sending its stop bit
    assign accept_d   = Data_Valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));
    assign last_bit_d = (cnt_q == LAST_IDX);

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data_i     (data_q),
        .par_typ_i  (par_typ_q),
        .par_bit_o  (par_bit_d)
    );

    // State register and bit counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; counter is cleared outside DATA so it enters DATA at 0
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE:   if (accept_d) state_d = ST_START;
            ST_START:  state_d = ST_DATA;
            ST_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (last_bit_d) state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = accept_d ? ST_START : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the state being entered, so outputs can be registered
    always_comb begin
        tx_d   = IDLE_LVL;
        busy_d = 1'b1;
        case (state_d)
            ST_IDLE:   busy_d = 1'b0;
            ST_START:  tx_d   = START_BIT;
            ST_DATA:   tx_d   = data_q[cnt_d];
            ST_PARITY: tx_d   = par_bit_d;
            ST_STOP:   tx_d   = STOP_BIT;
            default: begin
                tx_d   = IDLE_LVL;
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered line and busy outputs; reset forces the line idle at once
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_q   <= IDLE_LVL;
            busy_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

    // Payload and configuration captured only on the accepting edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else if (accept_d) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule : uart_tx
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one parallel byte per frame onto a single line: start bit, data LSB-first, optional even/odd parity, one stop bit. It is the transmit-side counterpart of the UART receiver's start/data/parity/stop checking chain and sits in the UART TX clock domain. One `CLK` cycle equals one bit period; upstream prescaling generates `CLK`.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `CLK` input, 1 bit: TX bit clock. All state changes occur on its rising edge.
- `RST` input, 1 bit: active-low reset, asserted asynchronously.
- `P_DATA` input, `DATA_WIDTH` bits: parallel payload, sampled only on acceptance.
- `Data_Valid` input, 1 bit: request to send `P_DATA`, qualified by the acceptance rule.
- `PAR_EN` input, 1 bit: 1 means a parity bit is appended. Sampled on acceptance.
- `PAR_TYP` input, 1 bit: 0 selects even parity, 1 selects odd parity. Sampled on acceptance.
- `TX_OUT` output, 1 bit: serial line, idle high, registered.
- `Busy` output, 1 bit: high while a frame occupies the line, registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **Acceptance.** A rising edge accepts a frame when `Data_Valid`=1 and the FSM is in IDLE, or in STOP (back-to-back). The accepting edge does the following:
  - latches `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers;
  - moves the FSM to START.
- **Ignored requests.** `Data_Valid` in START, DATA or PARITY is ignored, with no queuing. Input changes after acceptance do not affect the frame in flight.
- **START:** `TX_OUT`=0 for 1 cycle, then DATA.
- **DATA:**
  - `TX_OUT` = latched bit[idx], idx running 0 to `DATA_WIDTH`-1, one bit per cycle.
  - A `$clog2(DATA_WIDTH)`-bit counter tracks idx and resets to 0 on entering DATA.
  - After the last bit, go to PARITY if latched `PAR_EN`=1, otherwise to STOP.
- **PARITY:**
  - `TX_OUT` = ^data when even, ~^data when odd, computed on the latched data.
  - 1 cycle, then STOP.
- **STOP:** `TX_OUT`=1 for 1 cycle. Then go to START if acceptance occurs on that edge, otherwise to IDLE.
- **IDLE:** `TX_OUT`=1, `Busy`=0.
- **Reset:** `TX_OUT`=1, `Busy`=0, state IDLE, counter 0, latched data 0.
  - A reset mid-frame aborts the frame immediately; the line goes high asynchronously.
  - No partial frame resumes after reset release.

## Timing
- Outputs are registered. `TX_OUT` and `Busy` reflect the state entered at the most recent edge.
- Let the accepting edge be edge k:
  - Start bit is valid from k to k+1.
  - Data bit i is valid from k+1+i.
  - Parity, if enabled, is valid from k+1+`DATA_WIDTH`.
  - Stop bit follows.
- Frame length is `DATA_WIDTH`+2 cycles (10) without parity and `DATA_WIDTH`+3 cycles (11) with parity.
- `Busy` rises at edge k. It falls at the edge ending STOP, unless a back-to-back acceptance occurs on that same edge, in which case `Busy` stays high with no glitch.
- Back-to-back frames have zero idle cycles: one stop bit is immediately followed by the next start bit.
- If `Data_Valid` is held high continuously, frames repeat back-to-back, each using the `P_DATA` present at its own accepting edge.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
  - Parity constants: `PAR_EVEN`=0, `PAR_ODD`=1.
  - Line-level constants: `START_BIT`=0, `STOP_BIT`=1, `IDLE_LVL`=1.
  - The receiver reuses the same package.
- **Sub-module `parity_calc`:**
  - Combinational XOR-reduce of the latched data.
  - Applies the type select and produces `par_bit`.
  - Shared with the receiver's parity check.
- **Top `uart_tx`** contains:
  - FSM;
  - bit counter;
  - data/config latch;
  - output mux registered into `TX_OUT`.

## Test plan
- **No parity.** Reset, then pulse `Data_Valid` for 1 cycle with `P_DATA`=0xA5, `PAR_EN`=0.
  - Required `TX_OUT` sequence: 0,1,0,1,0,0,1,0,1,1.
  - `Busy` is high for exactly 10 cycles, then `TX_OUT` stays 1.
- **Parity, both types.**
  - 0xA5 with `PAR_EN`=1, `PAR_TYP`=0 gives parity bit 0.
  - 0xA5 with `PAR_TYP`=1 gives parity bit 1.
  - Both frames are 11 cycles.
  - 0x07 with even parity gives parity bit 1.
- **Back-to-back.** Hold `Data_Valid`=1 and change `P_DATA` from 0x3C to 0xC3 during the first frame's STOP cycle.
  - Frame 2 carries 0xC3.
  - The stop bit is immediately followed by the start bit.
  - `Busy` never drops.
- **Ignored request.** Pulse `Data_Valid` with 0xFF during the DATA state of a 0x00 frame.
  - Frame 1 still transmits all zeros.
  - No second frame follows.
- **Mid-frame reset.** Assert `RST` during data bit 3.
  - `TX_OUT`=1 and `Busy`=0 immediately, without waiting for an edge.
  - After release, the line stays idle until a new `Data_Valid`.
- **Input stability.** Change `PAR_EN`, `PAR_TYP` and `P_DATA` after acceptance.
  - Frame content and length are unchanged.
